qam_frame_builder: RTL and testbench
====================================

# qam_frame_builder

Parametrised frame assembler between the bitstream source and `constellation_map`. It packs a serial bit stream into 2/4/6-bit symbols for QPSK, 16QAM or 64QAM. Each frame is a fixed-length pilot preamble followed by a fixed-length payload. Symbols leave through a valid/ready handshake, so downstream rate control can stall the source.

## Interface
- `MAX_BPS`, 6: width of `sym_out`; must be at least 6.
- `PILOT_LEN`, 32: pilot symbols per frame, at least 1.
- `PAYLOAD_LEN`, 256: payload symbols per frame, at least 1.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `enable` input 1: frame generation request.
- `mod_type` input 2: 00 = QPSK (2 b), 01 = 16QAM (4 b), 10 = 64QAM (6 b), 11 = reserved (treated as QPSK).
- `bit_in` input 1: serial payload bit, MSB of each symbol first.
- `bit_valid` input 1: `bit_in` is valid.
- `bit_ready` output 1: block accepts `bit_in` this cycle.
- `sym_out` output `MAX_BPS`: symbol, right-aligned; unused upper bits are 0.
- `sym_valid` output 1: `sym_out` is valid.
- `sym_ready` input 1: downstream accepts the symbol.
- `sym_is_pilot` output 1: current `sym_out` is a pilot symbol.
- `frame_start` output 1: one-cycle pulse when the first pilot of a frame is loaded.
- `frame_count` output 16: number of completed frames; wraps from 0xFFFF to 0.

## Operation
- States:
  - IDLE: if `enable`=1, go to PILOT, latch `mod_type` into `bps` and reseed the LFSR.
  - PILOT: after the `PILOT_LEN`-th pilot is loaded, go to PAYLOAD.
  - PAYLOAD: after the `PAYLOAD_LEN`-th payload symbol is loaded, go to PILOT if `enable`=1 (relatch `mod_type`, reseed), else go to IDLE.
- `mod_type` changes mid-frame are ignored until the next frame start.
- `enable` deasserted mid-frame: the current frame completes. No truncation.
- Output register: "free" means `sym_valid`=0 or `sym_ready`=1. Loads happen only when the register is free. `sym_valid` holds with `sym_out`/`sym_is_pilot` stable until `sym_valid & sym_ready`.
- Pilot generation: 7-bit LFSR, seed 7'h7F, feedback `new = l[6]^l[5]`, `l <= {l[5:0],new}`.
  - Output bit is `l[6]`; the LFSR advances once per pilot loaded.
  - Pilot symbol is all-ones in the low `bps` bits when the bit is 1, else 0.
  - The pilot sequence is identical in every frame.
- Payload packing:
  - Shift register `sh` plus bit counter `cnt`, in the range 0..`bps`.
  - `bit_ready` = (state==PAYLOAD) & (`cnt` < `bps`). A bit is accepted when `bit_valid & bit_ready`.
  - Accepted bit with `cnt`=`bps`-1 and output free: load `{sh, bit_in}` directly into the output and set `cnt` to 0.
  - Accepted bit with `cnt`=`bps`-1 and output not free: `cnt` becomes `bps` and `bit_ready` drops.
  - The packed word then loads on the first free cycle, and `cnt` returns to 0 in that same cycle.
- Symbol counter: counts symbols loaded in the current state; clears on each state change.
- `frame_count` increments in the cycle the last payload symbol is loaded.

## Timing
- Reset values: all outputs 0 (`bit_ready`=0, `sym_valid`=0, `sym_out`=0, `sym_is_pilot`=0, `frame_start`=0, `frame_count`=0). Internally: state IDLE, `cnt`=0, LFSR 7'h7F.
- Start-up: `enable` sampled high in IDLE at edge N gives the PILOT state after N. The first pilot loads at edge N+1, so `sym_valid`=1 and `frame_start`=1 after N+1.
- Pilot throughput: one pilot per cycle while `sym_ready`=1.
- Payload latency: `sym_valid` rises in the cycle after the edge that accepts a symbol's last bit, provided the output is free.
- Payload throughput: one symbol per `bps` cycles with `bit_valid`=`sym_ready`=1.
- Transitions:
  - PILOT to PAYLOAD: `bit_ready` rises in the cycle after the last pilot load.
  - PAYLOAD to PILOT: the first pilot of the next frame loads on the first free cycle after the last payload load.
- Stalls: with `sym_ready`=0, at most one packed word waits inside the block. `bit_ready` stays 0 until that word is loaded.
- Reset mid-operation: asynchronous clear to the reset values above. Partially packed bits are discarded.

## Test plan
- Reset, then `enable`=1, QPSK, `PILOT_LEN`=4, `PAYLOAD_LEN`=4, `sym_ready`=1:
  - 4 pilots 6'h03, each with `sym_is_pilot`=1.
  - `frame_start` pulses with the first pilot only.
  - `bit_ready` rises after the 4th pilot.
- Same setup, bits 1,0,1,1,0,0,1,0 fed continuously:
  - payload 2,3,0,2, one every 2 cycles;
  - `frame_count` goes 0→1 when the last symbol loads;
  - the next frame's pilots follow.
- 16QAM, same bits: payload 0xB, 0x2. 64QAM, bits 1,0,1,1,0,0: payload 0x2C, with upper bits 0.
- Backpressure: `sym_ready`=0 for 10 cycles mid-payload.
  - `sym_out` is stable throughout;
  - `bit_ready` drops once the packer is full;
  - no symbol is lost or duplicated after release.
- Mode change and stop:
  - change `mod_type` and drop `enable` mid-payload;
  - the current frame completes in the old mode, then state goes to IDLE with `sym_valid`=0;
  - re-enable: the new mode applies and the pilots repeat 6'h03-style all-ones.
- Assert `rst_n`=0 mid-symbol: all outputs are 0 immediately. Restart: the pilot sequence is identical to the first run and `frame_count`=0.

Source files
------------

// File: rtl/qam_frame_builder.sv
// Frame assembler: packs a serial bit stream into QPSK/16QAM/64QAM symbols and
// emits frames of LFSR pilots followed by payload over a valid/ready handshake.
module qam_frame_builder #(
    parameter int unsigned MAX_BPS     = 6,
    parameter int unsigned PILOT_LEN   = 32,
    parameter int unsigned PAYLOAD_LEN = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [1:0]         mod_type,
    input  logic               bit_in,
    input  logic               bit_valid,
    output logic               bit_ready,
    output logic [MAX_BPS-1:0] sym_out,
    output logic               sym_valid,
    input  logic               sym_ready,
    output logic               sym_is_pilot,
    output logic               frame_start,
    output logic [15:0]        frame_count
);
    localparam int unsigned LEN_MAX = (PILOT_LEN > PAYLOAD_LEN) ? PILOT_LEN : PAYLOAD_LEN;
    localparam int unsigned SCNT_W  = $clog2(LEN_MAX + 1);
    localparam int unsigned BPS_W   = 3;
    localparam logic [6:0]  LFSR_SEED = 7'h7F;

    typedef enum logic [1:0] {ST_IDLE, ST_PILOT, ST_PAYLOAD} state_t;

    state_t              state_q, state_d;
    logic [BPS_W-1:0]    bps_q, bps_d;
    logic [BPS_W-1:0]    cnt_q, cnt_d;
    logic [6:0]          lfsr_q, lfsr_d;
    logic [MAX_BPS-1:0]  sh_q, sh_d;
    logic [SCNT_W-1:0]   sym_cnt_q, sym_cnt_d;
    logic [MAX_BPS-1:0]  sym_out_q, sym_out_d;
    logic                sym_valid_q, sym_valid_d;
    logic                sym_is_pilot_q, sym_is_pilot_d;
    logic                frame_start_q, frame_start_d;
    logic [15:0]         frame_count_q, frame_count_d;
    logic                bit_ready_q, bit_ready_d;

    logic                free;
    logic                accept;
    logic                load_word;
    logic [MAX_BPS-1:0]  word;
    logic [MAX_BPS-1:0]  mask;

    // Reserved mode 11 falls back to QPSK.
    function automatic logic [BPS_W-1:0] bps_of(input logic [1:0] m);
        case (m)
            2'b01:   return 3'd4;
            2'b10:   return 3'd6;
            default: return 3'd2;
        endcase
    endfunction

    always_comb begin
        state_d        = state_q;
        bps_d          = bps_q;
        cnt_d          = cnt_q;
        lfsr_d         = lfsr_q;
        sh_d           = sh_q;
        sym_cnt_d      = sym_cnt_q;
        sym_out_d      = sym_out_q;
        sym_valid_d    = sym_valid_q;
        sym_is_pilot_d = sym_is_pilot_q;
        frame_start_d  = 1'b0;
        frame_count_d  = frame_count_q;
        load_word      = 1'b0;
        word           = '0;
        mask           = '0;

        for (int i = 0; i < int'(MAX_BPS); i++) begin
            mask[i] = (i < int'(bps_q));
        end

        free   = !sym_valid_q || sym_ready;
        accept = bit_valid && bit_ready_q;

        if (sym_valid_q && sym_ready) begin
            sym_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d   = ST_PILOT;
                    bps_d     = bps_of(mod_type);
                    lfsr_d    = LFSR_SEED;
                    sym_cnt_d = '0;
                    cnt_d     = '0;
                end
            end
            ST_PILOT: begin
                if (free) begin
                    sym_out_d      = lfsr_q[6] ? mask : '0;
                    sym_valid_d    = 1'b1;
                    sym_is_pilot_d = 1'b1;
                    lfsr_d         = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
                    frame_start_d  = (sym_cnt_q == '0);
                    if (sym_cnt_q == SCNT_W'(PILOT_LEN - 1)) begin
                        state_d   = ST_PAYLOAD;
                        sym_cnt_d = '0;
                        cnt_d     = '0;
                    end else begin
                        sym_cnt_d = sym_cnt_q + SCNT_W'(1);
                    end
                end
            end
            ST_PAYLOAD: begin
                // A full packer (cnt==bps) waits for the output register to free up.
                if (cnt_q == bps_q) begin
                    if (free) begin
                        load_word = 1'b1;
                        word      = sh_q;
                    end
                end else if (accept) begin
                    if (cnt_q == bps_q - 3'd1) begin
                        if (free) begin
                            load_word = 1'b1;
                            word      = {sh_q[MAX_BPS-2:0], bit_in};
                        end else begin
                            sh_d  = {sh_q[MAX_BPS-2:0], bit_in};
                            cnt_d = bps_q;
                        end
                    end else begin
                        sh_d  = {sh_q[MAX_BPS-2:0], bit_in};
                        cnt_d = cnt_q + 3'd1;
                    end
                end

                if (load_word) begin
                    sym_out_d      = word & mask;
                    sym_valid_d    = 1'b1;
                    sym_is_pilot_d = 1'b0;
                    cnt_d          = '0;
                    if (sym_cnt_q == SCNT_W'(PAYLOAD_LEN - 1)) begin
                        frame_count_d = frame_count_q + 16'd1;
                        sym_cnt_d     = '0;
                        if (enable) begin
                            state_d = ST_PILOT;
                            bps_d   = bps_of(mod_type);
                            lfsr_d  = LFSR_SEED;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        sym_cnt_d = sym_cnt_q + SCNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        bit_ready_d = (state_d == ST_PAYLOAD) && (cnt_d < bps_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            bps_q          <= 3'd2;
            cnt_q          <= '0;
            lfsr_q         <= LFSR_SEED;
            sh_q           <= '0;
            sym_cnt_q      <= '0;
            sym_out_q      <= '0;
            sym_valid_q    <= 1'b0;
            sym_is_pilot_q <= 1'b0;
            frame_start_q  <= 1'b0;
            frame_count_q  <= '0;
            bit_ready_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            bps_q          <= bps_d;
            cnt_q          <= cnt_d;
            lfsr_q         <= lfsr_d;
            sh_q           <= sh_d;
            sym_cnt_q      <= sym_cnt_d;
            sym_out_q      <= sym_out_d;
            sym_valid_q    <= sym_valid_d;
            sym_is_pilot_q <= sym_is_pilot_d;
            frame_start_q  <= frame_start_d;
            frame_count_q  <= frame_count_d;
            bit_ready_q    <= bit_ready_d;
        end
    end

    assign bit_ready    = bit_ready_q;
    assign sym_out      = sym_out_q;
    assign sym_valid    = sym_valid_q;
    assign sym_is_pilot = sym_is_pilot_q;
    assign frame_start  = frame_start_q;
    assign frame_count  = frame_count_q;
endmodule

// File: tb/tb_qam_frame_builder.sv
// Directed bench for qam_frame_builder: vector table for the first frames, then
// hand-written backpressure, reset and long-pilot LFSR sequences.
module tb_qam_frame_builder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  mod_type;
    logic        bit_in;
    logic        bit_valid;
    logic        bit_ready;
    logic [5:0]  sym_out;
    logic        sym_valid;
    logic        sym_ready;
    logic        sym_is_pilot;
    logic        frame_start;
    logic [15:0] frame_count;

    logic        l_en;
    logic        l_br, l_v, l_pil, l_fs;
    logic [5:0]  l_out;
    logic [15:0] l_fc;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        en;
        logic [1:0]  m;
        logic        b;
        logic        bv;
        logic        rdy;
        logic        e_br;
        logic        e_v;
        logic [5:0]  e_out;
        logic        e_pil;
        logic        e_fs;
        logic [15:0] e_fc;
    } vec_t;

    vec_t       vecs[$];
    logic [5:0] pay_q[$];
    logic [5:0] pil_q[$];

    always #5 clk = ~clk;

    qam_frame_builder #(.MAX_BPS(6), .PILOT_LEN(4), .PAYLOAD_LEN(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mod_type(mod_type),
        .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .sym_out(sym_out), .sym_valid(sym_valid), .sym_ready(sym_ready),
        .sym_is_pilot(sym_is_pilot), .frame_start(frame_start), .frame_count(frame_count)
    );

    // Long preamble so the pilot pattern runs past the all-ones seed bits.
    qam_frame_builder #(.MAX_BPS(6), .PILOT_LEN(14), .PAYLOAD_LEN(1)) u_lfsr (
        .clk(clk), .rst_n(rst_n), .enable(l_en), .mod_type(2'b00),
        .bit_in(1'b0), .bit_valid(1'b1), .bit_ready(l_br),
        .sym_out(l_out), .sym_valid(l_v), .sym_ready(1'b1),
        .sym_is_pilot(l_pil), .frame_start(l_fs), .frame_count(l_fc)
    );

    always @(posedge clk) begin
        if (rst_n && sym_valid && sym_ready && !sym_is_pilot) pay_q.push_back(sym_out);
        if (rst_n && l_v && l_pil) pil_q.push_back(l_out);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic en, input logic [1:0] m, input logic b, input logic bv,
                       input logic rdy);
        enable = en; mod_type = m; bit_in = b; bit_valid = bv; sym_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    function automatic void addv(input logic en, input logic [1:0] m, input logic b,
                                 input logic bv, input logic rdy, input logic ebr,
                                 input logic ev, input logic [5:0] eo, input logic ep,
                                 input logic efs, input logic [15:0] efc);
        vec_t v;
        v.en = en; v.m = m; v.b = b; v.bv = bv; v.rdy = rdy;
        v.e_br = ebr; v.e_v = ev; v.e_out = eo; v.e_pil = ep; v.e_fs = efs; v.e_fc = efc;
        vecs.push_back(v);
    endfunction

    // 64QAM symbol sent MSB first with sym_ready high; checks the loaded word.
    task automatic send_sym(input logic [5:0] w, input logic [15:0] efc, input logic ebr);
        for (int i = 5; i >= 0; i--) begin
            cyc(1'b1, 2'b10, w[i], 1'b1, 1'b1);
            if (i > 0) chk("pack bit_ready", 32'(bit_ready), 32'd1);
        end
        chk("pack sym_valid", 32'(sym_valid), 32'd1);
        chk("pack sym_out", 32'(sym_out), 32'(w));
        chk("pack is_pilot", 32'(sym_is_pilot), 32'd0);
        chk("pack frame_count", 32'(frame_count), 32'(efc));
        chk("pack bit_ready end", 32'(bit_ready), 32'(ebr));
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " bit_ready"}, 32'(bit_ready), 32'd0);
        chk({nm, " sym_valid"}, 32'(sym_valid), 32'd0);
        chk({nm, " sym_out"}, 32'(sym_out), 32'd0);
        chk({nm, " is_pilot"}, 32'(sym_is_pilot), 32'd0);
        chk({nm, " frame_start"}, 32'(frame_start), 32'd0);
        chk({nm, " frame_count"}, 32'(frame_count), 32'd0);
    endtask

    initial begin
        logic [5:0] bp;
        logic       bb;
        logic [5:0] exp_pay[12];
        logic [5:0] exp_pil[14];

        rst_n = 1'b0; l_en = 1'b0;
        enable = 1'b0; mod_type = 2'b00; bit_in = 1'b0; bit_valid = 1'b0; sym_ready = 1'b0;

        // en mod bit bv rdy | br v out pil fs fc
        // Frame 1 QPSK; mod_type moves to 16QAM mid-frame and applies to frame 2.
        addv(1, 2'b00, 0, 0, 1, 0, 0, 6'h00, 0, 0, 0);
        addv(1, 2'b00, 0, 0, 1, 0, 1, 6'h03, 1, 1, 0);
        addv(1, 2'b00, 0, 0, 1, 0, 1, 6'h03, 1, 0, 0);
        addv(1, 2'b00, 0, 0, 1, 0, 1, 6'h03, 1, 0, 0);
        addv(1, 2'b00, 0, 0, 1, 1, 1, 6'h03, 1, 0, 0);
        addv(1, 2'b01, 1, 1, 1, 1, 0, 6'h00, 0, 0, 0);
        addv(1, 2'b01, 0, 1, 1, 1, 1, 6'h02, 0, 0, 0);
        addv(1, 2'b01, 1, 1, 1, 1, 0, 6'h00, 0, 0, 0);
        addv(1, 2'b01, 1, 1, 1, 1, 1, 6'h03, 0, 0, 0);
        addv(1, 2'b01, 0, 1, 1, 1, 0, 6'h00, 0, 0, 0);
        addv(1, 2'b01, 0, 1, 1, 1, 1, 6'h00, 0, 0, 0);
        addv(1, 2'b01, 1, 1, 1, 1, 0, 6'h00, 0, 0, 0);
        addv(1, 2'b01, 0, 1, 1, 0, 1, 6'h02, 0, 0, 1);
        // Frame 2: 16QAM pilots, payload B,2 then F,5; enable drops mid-payload.
        addv(1, 2'b01, 0, 0, 1, 0, 1, 6'h0F, 1, 1, 1);
        addv(1, 2'b01, 0, 0, 1, 0, 1, 6'h0F, 1, 0, 1);
        addv(1, 2'b01, 0, 0, 1, 0, 1, 6'h0F, 1, 0, 1);
        addv(1, 2'b01, 0, 0, 1, 1, 1, 6'h0F, 1, 0, 1);
        addv(1, 2'b01, 1, 1, 1, 1, 0, 6'h00, 0, 0, 1);
        addv(1, 2'b01, 0, 1, 1, 1, 0, 6'h00, 0, 0, 1);
        addv(1, 2'b01, 1, 1, 1, 1, 0, 6'h00, 0, 0, 1);
        addv(1, 2'b01, 1, 1, 1, 1, 1, 6'h0B, 0, 0, 1);
        addv(1, 2'b01, 0, 1, 1, 1, 0, 6'h00, 0, 0, 1);
        addv(1, 2'b01, 0, 1, 1, 1, 0, 6'h00, 0, 0, 1);
        addv(1, 2'b01, 1, 1, 1, 1, 0, 6'h00, 0, 0, 1);
        addv(1, 2'b01, 0, 1, 1, 1, 1, 6'h02, 0, 0, 1);
        addv(0, 2'b10, 1, 1, 1, 1, 0, 6'h00, 0, 0, 1);
        addv(0, 2'b10, 1, 1, 1, 1, 0, 6'h00, 0, 0, 1);
        addv(0, 2'b10, 1, 1, 1, 1, 0, 6'h00, 0, 0, 1);
        addv(0, 2'b10, 1, 1, 1, 1, 1, 6'h0F, 0, 0, 1);
        addv(0, 2'b10, 0, 1, 1, 1, 0, 6'h00, 0, 0, 1);
        addv(0, 2'b10, 1, 1, 1, 1, 0, 6'h00, 0, 0, 1);
        addv(0, 2'b10, 0, 1, 1, 1, 0, 6'h00, 0, 0, 1);
        addv(0, 2'b10, 1, 1, 1, 0, 1, 6'h05, 0, 0, 2);
        addv(0, 2'b10, 0, 0, 1, 0, 0, 6'h00, 0, 0, 2);
        addv(0, 2'b10, 0, 0, 1, 0, 0, 6'h00, 0, 0, 2);
        // Re-enable in 64QAM.
        addv(1, 2'b10, 0, 0, 1, 0, 0, 6'h00, 0, 0, 2);
        addv(1, 2'b10, 0, 0, 1, 0, 1, 6'h3F, 1, 1, 2);
        addv(1, 2'b10, 0, 0, 1, 0, 1, 6'h3F, 1, 0, 2);
        addv(1, 2'b10, 0, 0, 1, 0, 1, 6'h3F, 1, 0, 2);
        addv(1, 2'b10, 0, 0, 1, 1, 1, 6'h3F, 1, 0, 2);

        exp_pay = '{6'h02, 6'h03, 6'h00, 6'h02, 6'h0B, 6'h02, 6'h0F, 6'h05,
                    6'h2C, 6'h39, 6'h15, 6'h01};
        exp_pil = '{6'h03, 6'h03, 6'h03, 6'h03, 6'h03, 6'h03, 6'h03,
                    6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h03};

        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].en, vecs[i].m, vecs[i].b, vecs[i].bv, vecs[i].rdy);
            chk($sformatf("v%0d bit_ready", i), 32'(bit_ready), 32'(vecs[i].e_br));
            chk($sformatf("v%0d sym_valid", i), 32'(sym_valid), 32'(vecs[i].e_v));
            chk($sformatf("v%0d frame_start", i), 32'(frame_start), 32'(vecs[i].e_fs));
            chk($sformatf("v%0d frame_count", i), 32'(frame_count), 32'(vecs[i].e_fc));
            if (vecs[i].e_v) begin
                chk($sformatf("v%0d sym_out", i), 32'(sym_out), 32'(vecs[i].e_out));
                chk($sformatf("v%0d is_pilot", i), 32'(sym_is_pilot), 32'(vecs[i].e_pil));
            end
        end

        // 64QAM payload, then a 10-cycle stall while the next symbol packs.
        send_sym(6'h2C, 16'd2, 1'b1);
        bp = 6'b111001;
        for (int k = 0; k < 10; k++) begin
            bb = 1'b0;
            if (k < 6) bb = bp[5-k];
            cyc(1'b1, 2'b10, bb, 1'b1, 1'b0);
            chk($sformatf("stall%0d sym_out", k), 32'(sym_out), 32'h2C);
            chk($sformatf("stall%0d sym_valid", k), 32'(sym_valid), 32'd1);
            chk($sformatf("stall%0d bit_ready", k), 32'(bit_ready), (k < 5) ? 32'd1 : 32'd0);
        end
        cyc(1'b1, 2'b10, 1'b0, 1'b1, 1'b1);
        chk("release sym_out", 32'(sym_out), 32'h39);
        chk("release sym_valid", 32'(sym_valid), 32'd1);
        chk("release bit_ready", 32'(bit_ready), 32'd1);
        send_sym(6'h15, 16'd2, 1'b1);
        send_sym(6'h01, 16'd3, 1'b0);

        // Next frame pilots follow immediately.
        for (int p = 0; p < 4; p++) begin
            cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
            chk($sformatf("f4 pilot%0d sym_out", p), 32'(sym_out), 32'h3F);
            chk($sformatf("f4 pilot%0d is_pilot", p), 32'(sym_is_pilot), 32'd1);
            chk($sformatf("f4 pilot%0d frame_start", p), 32'(frame_start), (p == 0) ? 32'd1 : 32'd0);
        end
        chk("f4 bit_ready", 32'(bit_ready), 32'd1);

        // Asynchronous reset with a symbol half packed.
        cyc(1'b1, 2'b10, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 2'b10, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 2'b10, 1'b1, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        chk("restart sym_valid", 32'(sym_valid), 32'd0);
        for (int p = 0; p < 4; p++) begin
            cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
            chk($sformatf("restart pilot%0d sym_out", p), 32'(sym_out), 32'h03);
            chk($sformatf("restart pilot%0d frame_start", p), 32'(frame_start), (p == 0) ? 32'd1 : 32'd0);
            chk($sformatf("restart pilot%0d frame_count", p), 32'(frame_count), 32'd0);
        end
        chk("restart bit_ready", 32'(bit_ready), 32'd1);
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);

        chk("payload count", 32'(pay_q.size()), 32'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < pay_q.size()) chk($sformatf("payload%0d", i), 32'(pay_q[i]), 32'(exp_pay[i]));
        end

        // Long preamble: two frames must show the same pilot pattern.
        l_en = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        l_en = 1'b0;
        chk("lfsr pilot count", (pil_q.size() >= 28) ? 32'd1 : 32'd0, 32'd1);
        for (int i = 0; i < 28; i++) begin
            if (i < pil_q.size()) chk($sformatf("lfsr pilot%0d", i), 32'(pil_q[i]), 32'(exp_pil[i % 14]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
